// File: rtl/obstacle_control.sv
// Purpose : control FSM for the bouncing-block datapath (draw, wait, erase, probe, move).
// Latency : timer_done (run=1) to next draw plot = 6 clocks; direction toggles are same-cycle Mealy on obstacle.
// Backpress: run=0 parks the FSM in S_WAIT with the frame timer frozen; no other stall source.
//
// Ports:
//   i_clk, i_reset (async active-low)      clock / reset
//   i_run                                 1 = animate, 0 = freeze in S_WAIT
//   i_xdir, i_ydir                        current datapath directions (1 = +, 0 = -)
//   i_timer_done                          frame timer expired
//   i_obstacle                            probed next position is blocked
//   o_en_*/o_s_*                          datapath register enables and selects
//   o_s_color, o_s_obs_xy, o_plot         colour select, probe select, VGA write strobe
//   o_bounce_count                        saturating count of direction-reversal cycles
module obstacle_control #(
    parameter int BCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_xdir,
    input  logic              i_ydir,
    input  logic              i_timer_done,
    input  logic              i_obstacle,
    output logic              o_en_xpos,
    output logic [1:0]        o_s_xpos,
    output logic              o_en_ypos,
    output logic [1:0]        o_s_ypos,
    output logic              o_en_xdir,
    output logic              o_s_xdir,
    output logic              o_en_ydir,
    output logic              o_s_ydir,
    output logic              o_en_timer,
    output logic              o_s_timer,
    output logic              o_s_color,
    output logic [1:0]        o_s_obs_xy,
    output logic              o_plot,
    output logic [BCNT_W-1:0] o_bounce_count
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_PRX   = 3'd4,
        S_PRY   = 3'd5,
        S_PRD   = 3'd6,
        S_MOVE  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_bx;
    logic                r_by;
    logic [BCNT_W-1:0]   r_bounce;
    logic                w_toggle;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_toggle   = 1'b0;
        o_en_xpos  = 1'b0;
        o_s_xpos   = 2'd3;
        o_en_ypos  = 1'b0;
        o_s_ypos   = 2'd3;
        o_en_xdir  = 1'b0;
        o_s_xdir   = 1'b0;
        o_en_ydir  = 1'b0;
        o_s_ydir   = 1'b0;
        o_en_timer = 1'b0;
        o_s_timer  = 1'b0;
        o_s_color  = 1'b0;
        o_s_obs_xy = 2'd3;
        o_plot     = 1'b0;
        case (r_state)
            S_INIT: begin
                o_en_xpos  = 1'b1;
                o_s_xpos   = 2'd0;
                o_en_ypos  = 1'b1;
                o_s_ypos   = 2'd0;
                o_en_xdir  = 1'b1;
                o_en_ydir  = 1'b1;
                o_en_timer = 1'b1;
                w_next     = S_DRAW;
            end
            S_DRAW: begin
                o_s_color  = 1'b1;
                o_plot     = 1'b1;
                o_en_timer = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                o_en_timer = i_run;
                o_s_timer  = 1'b1;
                if (i_timer_done && i_run) begin
                    w_next = S_ERASE;
                end
            end
            S_ERASE: begin
                o_plot = 1'b1;
                w_next = S_PRX;
            end
            S_PRX: begin
                o_s_obs_xy = 2'd0;
                if (i_obstacle) begin
                    o_en_xdir = 1'b1;
                    o_s_xdir  = 1'b1;
                    w_toggle  = 1'b1;
                end
                w_next = S_PRY;
            end
            S_PRY: begin
                o_s_obs_xy = 2'd1;
                if (i_obstacle) begin
                    o_en_ydir = 1'b1;
                    o_s_ydir  = 1'b1;
                    w_toggle  = 1'b1;
                end
                w_next = S_PRD;
            end
            S_PRD: begin
                o_s_obs_xy = 2'd2;
                // Diagonal hit only matters when neither axis already bounced.
                if (i_obstacle && !r_bx && !r_by) begin
                    o_en_xdir = 1'b1;
                    o_s_xdir  = 1'b1;
                    o_en_ydir = 1'b1;
                    o_s_ydir  = 1'b1;
                    w_toggle  = 1'b1;
                end
                w_next = S_MOVE;
            end
            S_MOVE: begin
                o_en_xpos = 1'b1;
                o_s_xpos  = i_xdir ? 2'd1 : 2'd2;
                o_en_ypos = 1'b1;
                o_s_ypos  = i_ydir ? 2'd1 : 2'd2;
                w_next    = S_DRAW;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bx     <= 1'b0;
            r_by     <= 1'b0;
            r_bounce <= '0;
        end else begin
            if (r_state == S_PRX && i_obstacle) begin
                r_bx <= 1'b1;
            end else if (r_state == S_MOVE || r_state == S_INIT) begin
                r_bx <= 1'b0;
            end
            if (r_state == S_PRY && i_obstacle) begin
                r_by <= 1'b1;
            end else if (r_state == S_MOVE || r_state == S_INIT) begin
                r_by <= 1'b0;
            end
            // One count per toggle cycle; a corner toggle of both axes counts once.
            if (w_toggle && (r_bounce != {BCNT_W{1'b1}})) begin
                r_bounce <= r_bounce + 1'b1;
            end
        end
    end

    assign o_bounce_count = r_bounce;

endmodule

// File: doc/obstacle_control.md
Name: obstacle_control

Overview:
- Control FSM for the obstacle/bouncing-block datapath. It drives every select and enable on the datapath: position, direction, timer, colour and obstacle probe.
- It consumes the datapath status flags (xdir, ydir, timer_done, obstacle) and sequences draw → wait → erase → probe → move.
- Sits beside datapath inside the obstacle top level. Also emits the VGA plot strobe and a saturating bounce counter.

Parameters:
- BCNT_W, 8, width of bounce_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = animate; 0 = freeze in S_WAIT.
- xdir  in  1  datapath x direction; 1 = +x, 0 = -x.
- ydir  in  1  datapath y direction; 1 = +y, 0 = -y.
- timer_done  in  1  datapath frame timer reached zero.
- obstacle  in  1  the probed next position (per s_obs_xy) hits a wall or obstacle.
- en_xpos  out  1  xpos register enable.
- s_xpos  out  2  0 load start X, 1 xpos+1, 2 xpos-1, 3 hold.
- en_ypos  out  1  ypos register enable.
- s_ypos  out  2  0 load start Y, 1 ypos+1, 2 ypos-1, 3 hold.
- en_xdir  out  1  xdir register enable.
- s_xdir  out  1  0 load initial (1), 1 toggle.
- en_ydir  out  1  ydir register enable.
- s_ydir  out  1  0 load initial (1), 1 toggle.
- en_timer  out  1  timer enable.
- s_timer  out  1  0 load frame count, 1 decrement.
- s_color  out  1  0 background (erase), 1 block colour.
- s_obs_xy  out  2  probe: 0 x-step, 1 y-step, 2 diagonal, 3 none.
- plot  out  1  one-cycle VGA pixel write strobe.
- bounce_count  out  BCNT_W  saturating count of direction reversals.

Behaviour:
- States: S_INIT, S_DRAW, S_WAIT, S_ERASE, S_PRX, S_PRY, S_PRD, S_MOVE. Encoding is free.
- Defaults in every state: all en_* = 0, s_xpos = s_ypos = 3, s_xdir = s_ydir = 0, s_timer = 0, s_color = 0, s_obs_xy = 3, plot = 0.
- Outputs are Moore decode of state, except the en_xdir/en_ydir terms in the probe states, which are Mealy on obstacle.
- reset low, at any time including mid-frame: state → S_INIT asynchronously; bounce_count → 0; bx, by → 0.
- S_INIT: en_xpos = en_ypos = 1, s_xpos = s_ypos = 0; en_xdir = en_ydir = 1 (load initial); en_timer = 1, s_timer = 0. Next state S_DRAW.
- S_DRAW: s_color = 1, plot = 1; en_timer = 1, s_timer = 0 (reload). Next state S_WAIT.
- S_WAIT:
  - en_timer = run, s_timer = 1.
  - If timer_done & run → S_ERASE; else stay.
  - run = 0 freezes the timer and holds the state.
  - timer_done with run = 0 does not advance.
- S_ERASE: s_color = 0, plot = 1. Next state S_PRX. Erase always uses the same coordinates as the preceding draw.
- S_PRX:
  - s_obs_xy = 0.
  - If obstacle: en_xdir = 1, s_xdir = 1, and set internal flag bx.
  - Next state S_PRY.
- S_PRY:
  - s_obs_xy = 1.
  - If obstacle: en_ydir = 1, s_ydir = 1, set by.
  - Next state S_PRD.
- S_PRD:
  - s_obs_xy = 2.
  - If obstacle & ~bx & ~by: toggle both directions (corner hit).
  - Next state S_MOVE.
- S_MOVE:
  - en_xpos = en_ypos = 1.
  - s_xpos = xdir ? 1 : 2; s_ypos = ydir ? 1 : 2. Uses the post-toggle direction values.
  - Clear bx, by. Next state S_DRAW.
- bounce_count:
  - +1 per cycle in which any direction toggle is issued. A corner toggle counts as 1.
  - Saturates at 2^BCNT_W - 1; never wraps.
- Frame latency from timer_done (run = 1) to the next draw plot: 6 clocks (ERASE, PRX, PRY, PRD, MOVE, DRAW).
- plot is asserted only in S_DRAW and S_ERASE, exactly one cycle each per frame.
- No two plot cycles are adjacent, and en_xpos never coincides with plot.

Test Plan:
- Reset release, run = 1, timer_done = 0, obstacle = 0:
  - Cycle 0 in S_INIT: en_xpos = 1, s_xpos = 0, en_timer = 1, s_timer = 0, plot = 0.
  - Cycle 1: plot = 1, s_color = 1.
  - Then S_WAIT with en_timer = 1, s_timer = 1.
- Free frame, xdir = 1, ydir = 0, obstacle = 0, pulse timer_done:
  - Sequence is plot/s_color = 0, then probes s_obs_xy = 0, 1, 2 with no en_xdir/en_ydir.
  - Then en_xpos = en_ypos = 1, s_xpos = 1, s_ypos = 2.
  - Then plot/s_color = 1, 6 clocks after timer_done.
- obstacle = 1 only while s_obs_xy = 0:
  - en_xdir = 1, s_xdir = 1 in S_PRX only; bounce_count 0 → 1.
  - No diagonal toggle in S_PRD, even if obstacle = 1 there.
- obstacle = 1 only while s_obs_xy = 2: both en_xdir and en_ydir = 1 with toggle selects in S_PRD; bounce_count += 1.
- run = 0 in S_WAIT with timer_done = 1 for 20 cycles: state held, en_timer = 0, plot = 0. run = 1 → erase on the next clock.
- Saturation and async reset:
  - BCNT_W = 2: 5 bounces give bounce_count = 3.
  - reset asserted mid-S_PRY between clock edges: outputs immediately show the S_INIT decode and bounce_count = 0.
